// File: rtl/intr_source_capture.sv
// Conditions raw peripheral interrupt lines (sync, polarity, edge/level, mask) for the priority controller.
// Optional OVERFLOW register and overflow_o output are built when INTR_CAPTURE_OVERFLOW_EN is defined.
module intr_source_capture #(
  parameter int INTR_WIDTH  = 16,
  parameter int INTR_ADDR   = 4,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [INTR_WIDTH-1:0] irq_raw_i,
  output logic [INTR_WIDTH-1:0] intr_o,
  input  logic [INTR_ADDR-1:0]  intr_id_i,
  input  logic                  intr_serviced_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [INTR_WIDTH-1:0] wr_data_i,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic                  valid_i,
  output logic [INTR_WIDTH-1:0] rd_data_o,
  output logic                  ready_o,
  output logic                  overflow_o
);

  localparam logic [ADDR_WIDTH-1:0] A_MASK = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] A_EDGE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_POL  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_PEND = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_OVF  = ADDR_WIDTH'(4);

  logic [INTR_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [INTR_WIDTH-1:0] mask_q, edge_q, pol_q, pend_q, s_d_q;
  logic                  svc_d_q;
  logic [INTR_WIDTH-1:0] s, rise, svc_clr, w1c_pend, edge_nxt, mode_chg, pend_edge, pend_nxt;
  logic [INTR_WIDTH-1:0] rd_mux;
  logic                  wr_acc, rd_acc, svc_rise;

  // Handshake: a cycle with valid_i and wr_en_i (write wins over rd_en_i) or valid_i and rd_en_i
  // is accepted at the clock edge; ready_o pulses for exactly one cycle afterwards, with rd_data_o
  // holding the read value for reads and 0 otherwise. There is no back-pressure.
  assign wr_acc = valid_i & wr_en_i;
  assign rd_acc = valid_i & rd_en_i & ~wr_en_i;

  assign s        = sync_q[SYNC_STAGES-1] ^ pol_q;
  assign rise     = s & ~s_d_q;
  assign svc_rise = intr_serviced_i & ~svc_d_q;
  assign svc_clr  = svc_rise ? (INTR_WIDTH'(1) << intr_id_i) : '0;
  assign w1c_pend = (wr_acc && addr_i == A_PEND) ? wr_data_i : '0;
  assign edge_nxt = (wr_acc && addr_i == A_EDGE) ? wr_data_i : edge_q;
  assign mode_chg = edge_nxt ^ edge_q;

  // Set beats clear; level bits simply track s; a mode switch wipes the bit for one cycle.
  assign pend_edge = (pend_q & ~(svc_clr | w1c_pend)) | rise;
  assign pend_nxt  = ((edge_q & pend_edge) | (~edge_q & s)) & ~mode_chg;

`ifdef INTR_CAPTURE_OVERFLOW_EN
  logic [INTR_WIDTH-1:0] ovf_q, ovf_nxt, w1c_ovf;
  assign w1c_ovf = (wr_acc && addr_i == A_OVF) ? wr_data_i : '0;
  assign ovf_nxt = (ovf_q & ~w1c_ovf) | (rise & pend_q & edge_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q      <= '0;
      overflow_o <= 1'b0;
    end else begin
      ovf_q      <= ovf_nxt;
      overflow_o <= |ovf_q;
    end
  end
`else
  assign overflow_o = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (addr_i)
      A_MASK: rd_mux = mask_q;
      A_EDGE: rd_mux = edge_q;
      A_POL:  rd_mux = pol_q;
      A_PEND: rd_mux = pend_q;
`ifdef INTR_CAPTURE_OVERFLOW_EN
      A_OVF:  rd_mux = ovf_q;
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      mask_q    <= '0;
      edge_q    <= '0;
      pol_q     <= '0;
      pend_q    <= '0;
      s_d_q     <= '0;
      svc_d_q   <= 1'b0;
      intr_o    <= '0;
      rd_data_o <= '0;
      ready_o   <= 1'b0;
    end else begin
      sync_q[0] <= irq_raw_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      if (wr_acc && addr_i == A_MASK) mask_q <= wr_data_i;
      if (wr_acc && addr_i == A_POL)  pol_q  <= wr_data_i;
      edge_q    <= edge_nxt;
      pend_q    <= pend_nxt;
      s_d_q     <= s;
      svc_d_q   <= intr_serviced_i;
      intr_o    <= pend_q & mask_q;
      ready_o   <= valid_i & (wr_en_i | rd_en_i);
      rd_data_o <= rd_acc ? rd_mux : '0;
    end
  end

endmodule

// File: tb/tb_intr_source_capture.sv
// Bench for intr_source_capture: register table, directed multi-cycle sequences, randomized run vs reference model.
// Expectations for the OVERFLOW feature follow INTR_CAPTURE_OVERFLOW_EN.
module tb_intr_source_capture;
  localparam int W  = 16;
  localparam int IA = 4;
  localparam int AW = 4;
  localparam int SS = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [W-1:0]  irq_raw_i = '0;
  logic [W-1:0]  intr_o;
  logic [IA-1:0] intr_id_i = '0;
  logic          intr_serviced_i = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [W-1:0]  wr_data_i = '0;
  logic          wr_en_i = 1'b0;
  logic          rd_en_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [W-1:0]  rd_data_o;
  logic          ready_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  intr_source_capture #(.INTR_WIDTH(W), .INTR_ADDR(IA), .ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .irq_raw_i(irq_raw_i), .intr_o(intr_o),
    .intr_id_i(intr_id_i), .intr_serviced_i(intr_serviced_i), .addr_i(addr_i),
    .wr_data_i(wr_data_i), .wr_en_i(wr_en_i), .rd_en_i(rd_en_i), .valid_i(valid_i),
    .rd_data_o(rd_data_o), .ready_o(ready_o), .overflow_o(overflow_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

`ifdef INTR_CAPTURE_OVERFLOW_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  // ---------------- reference model (register-level view of the behaviour) ----------------
  logic [W-1:0] m_mask, m_edge, m_pol, m_pend, m_ovf, m_prev_s, m_intr, m_rd;
  logic         m_serv_prev, m_ready, m_ovf_o;
  logic [W-1:0] m_hist[$];   // sampled raw lines, newest first

  task automatic model_reset();
    m_mask = '0; m_edge = '0; m_pol = '0; m_pend = '0; m_ovf = '0; m_prev_s = '0;
    m_intr = '0; m_rd = '0; m_serv_prev = 1'b0; m_ready = 1'b0; m_ovf_o = 1'b0;
    m_hist = {};
    for (int k = 0; k < SS; k++) m_hist.push_back('0);
  endtask

  function automatic logic [W-1:0] model_reg(input logic [AW-1:0] a);
    case (a)
      4'd0: return m_mask;
      4'd1: return m_edge;
      4'd2: return m_pol;
      4'd3: return m_pend;
      4'd4: return OVF_ON ? m_ovf : '0;
      default: return '0;
    endcase
  endfunction

  task automatic model_edge();
    logic [W-1:0] s_now, rise, n_pend, n_ovf, n_edge;
    logic wr, rd, svc;
    s_now  = m_hist[SS-1] ^ m_pol;
    rise   = s_now & ~m_prev_s;
    wr     = valid_i & wr_en_i;
    rd     = valid_i & rd_en_i & ~wr_en_i;
    svc    = intr_serviced_i & ~m_serv_prev;
    n_edge = (wr && addr_i == 4'd1) ? wr_data_i : m_edge;
    n_pend = '0;
    n_ovf  = '0;
    for (int i = 0; i < W; i++) begin
      if (n_edge[i] != m_edge[i]) n_pend[i] = 1'b0;
      else if (!m_edge[i]) n_pend[i] = s_now[i];
      else if (rise[i]) n_pend[i] = 1'b1;
      else if ((wr && addr_i == 4'd3 && wr_data_i[i]) || (svc && int'(intr_id_i) == i)) n_pend[i] = 1'b0;
      else n_pend[i] = m_pend[i];
      if (OVF_ON && m_edge[i] && rise[i] && m_pend[i]) n_ovf[i] = 1'b1;
      else if (wr && addr_i == 4'd4 && wr_data_i[i]) n_ovf[i] = 1'b0;
      else n_ovf[i] = m_ovf[i];
    end
    m_intr  = m_pend & m_mask;
    m_ready = valid_i & (wr_en_i | rd_en_i);
    m_rd    = rd ? model_reg(addr_i) : '0;
    m_ovf_o = |m_ovf;
    if (wr && addr_i == 4'd0) m_mask = wr_data_i;
    if (wr && addr_i == 4'd2) m_pol = wr_data_i;
    m_edge = n_edge; m_pend = n_pend; m_ovf = n_ovf;
    m_prev_s = s_now; m_serv_prev = intr_serviced_i;
    m_hist.push_front(irq_raw_i);
    void'(m_hist.pop_back());
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    valid_i = 1'b0; wr_en_i = 1'b0; rd_en_i = 1'b0; addr_i = '0; wr_data_i = '0;
  endtask

  task automatic reg_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    valid_i = 1'b1; wr_en_i = 1'b1; rd_en_i = 1'b0; addr_i = a; wr_data_i = d;
    tick();
    idle_bus();
    chk1("wr_ready", ready_o, 1'b1);
  endtask

  task automatic reg_read(input logic [AW-1:0] a, input logic [W-1:0] exp, input string name);
    valid_i = 1'b1; wr_en_i = 1'b0; rd_en_i = 1'b1; addr_i = a;
    tick();
    idle_bus();
    chk(name, rd_data_o, exp);
    chk1({name, "_ready"}, ready_o, 1'b1);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_bus();
    irq_raw_i = '0; intr_serviced_i = 1'b0; intr_id_i = '0;
    repeat (3) tick();
    rst_ni = 1'b1;
    model_reset();
  endtask

  // ---------------- register-access vector table ----------------
  typedef struct {
    logic          v, w, r;
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    logic [W-1:0]  exp_rd;
    logic          exp_rdy;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic w, input logic r, input logic [AW-1:0] a,
                              input logic [W-1:0] d, input logic [W-1:0] e, input logic y);
    vec_t t;
    t.v = v; t.w = w; t.r = r; t.a = a; t.d = d; t.exp_rd = e; t.exp_rdy = y;
    return t;
  endfunction

  vec_t tbl[15];

  initial begin
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 4'd0, 16'hA5A5, 16'h0000, 1'b1);
    tbl[1]  = mk(1'b1, 1'b0, 1'b1, 4'd0, 16'h0000, 16'hA5A5, 1'b1);
    tbl[2]  = mk(1'b1, 1'b1, 1'b0, 4'd1, 16'hFFFF, 16'h0000, 1'b1);
    tbl[3]  = mk(1'b1, 1'b0, 1'b1, 4'd1, 16'h0000, 16'hFFFF, 1'b1);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 4'd2, 16'h00F0, 16'h0000, 1'b1);
    tbl[5]  = mk(1'b1, 1'b0, 1'b1, 4'd2, 16'h0000, 16'h00F0, 1'b1);
    tbl[6]  = mk(1'b1, 1'b1, 1'b1, 4'd0, 16'h00FF, 16'h0000, 1'b1);
    tbl[7]  = mk(1'b1, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h00FF, 1'b1);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 4'd9, 16'hFFFF, 16'h0000, 1'b1);
    tbl[9]  = mk(1'b1, 1'b0, 1'b1, 4'd9, 16'h0000, 16'h0000, 1'b1);
    tbl[10] = mk(1'b1, 1'b0, 1'b1, 4'd4, 16'h0000, 16'h0000, 1'b1);
    tbl[11] = mk(1'b0, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h0000, 1'b0);
    tbl[12] = mk(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0);
    tbl[13] = mk(1'b1, 1'b0, 1'b1, 4'd3, 16'h0000, 16'h00F0, 1'b1);
    tbl[14] = mk(1'b1, 1'b0, 1'b1, 4'd0, 16'h0000, 16'h00FF, 1'b1);

    // reset state
    model_reset();
    rst_ni = 1'b0;
    #12;
    chk("rst_intr", intr_o, '0);
    chk("rst_rd", rd_data_o, '0);
    chk1("rst_ready", ready_o, 1'b0);
    chk1("rst_ovf", overflow_o, 1'b0);
    @(posedge clk_i); #1;
    do_reset();

    // table: back-to-back accesses, one per cycle
    for (int i = 0; i < 15; i++) begin
      valid_i = tbl[i].v; wr_en_i = tbl[i].w; rd_en_i = tbl[i].r;
      addr_i = tbl[i].a; wr_data_i = tbl[i].d;
      exp_q.push_back(tbl[i].exp_rd);
      tick();
      chk($sformatf("tbl%0d_rd", i), rd_data_o, exp_q.pop_front());
      chk1($sformatf("tbl%0d_ready", i), ready_o, tbl[i].exp_rdy);
    end
    idle_bus();
    do_reset();

    // single-cycle pulse on edge source 0
    reg_write(4'd0, 16'hFFFF);
    reg_write(4'd1, 16'h0001);
    reg_write(4'd2, 16'h0000);
    irq_raw_i = 16'h0001; tick(); irq_raw_i = '0;
    tick(); tick();
    chk("edge_latency_early", intr_o, 16'h0000);
    tick();
    chk("edge_latency", intr_o, 16'h0001);
    repeat (3) tick();
    chk("edge_held", intr_o, 16'h0001);
    reg_read(4'd3, 16'h0001, "pending_rd");

    // serviced held high clears once; a new edge while held stays pending
    intr_id_i = 4'd0; intr_serviced_i = 1'b1;
    tick(); tick();
    chk("svc_clear", intr_o, 16'h0000);
    repeat (3) tick();
    irq_raw_i = 16'h0001; tick(); irq_raw_i = '0;
    repeat (3) tick();
    chk("svc_held_no_reclear", intr_o, 16'h0001);
    intr_serviced_i = 1'b0; tick();
    reg_write(4'd3, 16'h0001); tick();
    chk("w1c_edge", intr_o, 16'h0000);

    // level source 5, active-low
    irq_raw_i = 16'h0020;
    reg_write(4'd2, 16'h0020);
    repeat (5) tick();
    chk("level_inactive", intr_o, 16'h0000);
    irq_raw_i = 16'h0000;
    repeat (3) tick();
    chk("level_latency_early", intr_o, 16'h0000);
    tick();
    chk("level_active", intr_o, 16'h0020);
    reg_write(4'd3, 16'h0020); repeat (2) tick();
    chk("level_w1c_ignored", intr_o, 16'h0020);
    reg_write(4'd1, 16'h0021); tick();
    chk("mode_change_clear", intr_o, 16'h0000);
    repeat (2) tick();
    chk("mode_change_no_spurious", intr_o, 16'h0000);
    reg_write(4'd1, 16'h0001);
    irq_raw_i = 16'h0020;
    repeat (3) tick();
    chk("level_release_early", intr_o, 16'h0020);
    tick();
    chk("level_release", intr_o, 16'h0000);

    // masked edge on source 3, then unmask; set beats same-cycle W1C
    reg_write(4'd0, 16'h0000);
    reg_write(4'd1, 16'h0008);
    irq_raw_i[3] = 1'b1; tick(); irq_raw_i[3] = 1'b0;
    repeat (5) tick();
    chk("masked_edge", intr_o, 16'h0000);
    reg_read(4'd3, 16'h0008, "masked_pending");
    reg_write(4'd0, 16'h0008);
    chk("unmask_before", intr_o, 16'h0000);
    tick();
    chk("unmask_next_clk", intr_o, 16'h0008);
    irq_raw_i[3] = 1'b1; tick(); irq_raw_i[3] = 1'b0; tick();
    valid_i = 1'b1; wr_en_i = 1'b1; addr_i = 4'd3; wr_data_i = 16'h0008;
    tick(); idle_bus(); tick();
    chk("set_wins_w1c", intr_o, 16'h0008);
    reg_write(4'd3, 16'h0008); tick();
    chk("w1c_clears", intr_o, 16'h0000);

    // overflow on source 2
    reg_write(4'd4, 16'hFFFF);
    reg_write(4'd0, 16'hFFFF);
    reg_write(4'd1, 16'h0004);
    irq_raw_i[2] = 1'b1; tick(); irq_raw_i[2] = 1'b0;
    repeat (5) tick();
    chk("ovf_first_edge", intr_o, 16'h0004);
    chk1("ovf_first_out", overflow_o, 1'b0);
    irq_raw_i[2] = 1'b1; tick(); irq_raw_i[2] = 1'b0;
    repeat (5) tick();
    reg_read(4'd4, OVF_ON ? 16'h0004 : 16'h0000, "ovf_reg");
    chk1("ovf_out", overflow_o, OVF_ON);
    reg_write(4'd4, 16'h0004); tick(); tick();
    chk1("ovf_w1c", overflow_o, 1'b0);

    // asynchronous reset mid-cycle
    chk("pre_reset_intr", intr_o, 16'h0004);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_reset_intr", intr_o, 16'h0000);
    do_reset();
    reg_read(4'd0, 16'h0000, "reset_mask");
    do_reset();

    // randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      irq_raw_i = irq_raw_i ^ W'($urandom & $urandom & $urandom);
      valid_i   = ($urandom_range(0, 2) == 0);
      wr_en_i   = 1'($urandom_range(0, 1));
      rd_en_i   = 1'($urandom_range(0, 1));
      addr_i    = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(5, 15)) : AW'($urandom_range(0, 4));
      wr_data_i = W'($urandom);
      if ($urandom_range(0, 3) == 0) intr_serviced_i = ~intr_serviced_i;
      intr_id_i = IA'($urandom_range(0, 15));
      tick();
      chk("rnd_intr", intr_o, m_intr);
      chk("rnd_rd", rd_data_o, m_rd);
      chk1("rnd_ready", ready_o, m_ready);
      chk1("rnd_ovf", overflow_o, m_ovf_o);
    end
    idle_bus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
